tl_src_arbiter: RTL and testbench
=================================

// Module: tl_src_arbiter
// PURPOSE
//  2:1 TileLink-UL arbiter sharing one A/D channel pair (64b data, 31b addr) between two requester ports.
//  Round-robin grant on A; locks the grant for a whole multi-beat Put burst.
//  Prefixes port index onto source (7b out = {port, 6b src}); routes D responses back by source MSB.
//  Sits between core-side masters and the single outbound TL port bridge.
// PARAMETERS
//  ADDR_W  31  address width
//  DATA_W  64  data width; BEAT_LG = log2(DATA_W/8) = 3
//  SRC_W   6   per-port source width; outbound source is SRC_W+1
// PORTS
//  clock            in   1        single clock
//  reset_n          in   1        asynchronous, active-low reset
//  aK_valid/ready   in/out 1      K in {0,1}: requester A handshake
//  aK_opcode/param  in   3/3      A opcode, param
//  aK_size          in   3        log2 bytes
//  aK_source        in   SRC_W    requester source id
//  aK_address       in   ADDR_W   byte address
//  aK_mask/data     in   8/64     byte mask, write data
//  a_valid/ready    out/in 1      outbound A handshake
//  a_opcode/param/size out 3 each; a_source out SRC_W+1; a_address/mask/data out ADDR_W/8/64
//  d_valid/ready    in/out 1      inbound D handshake
//  d_opcode/param/size in 3/2/3;  d_source in SRC_W+1; d_denied/d_corrupt in 1; d_data in 64
//  dK_valid/ready   out/in 1      per-port D handshake; dK_* fields = d_* with source[SRC_W-1:0]
// BEHAVIOUR
//  - Zero-latency: A and D are combinational muxes; state = rr_ptr, lock, lock_port, beats_left.
//  - Reset: rr_ptr=0 (port 0 preferred), lock=0, beats_left=0; a_valid=0, aK_ready=0, dK_valid=0 while reset_n=0.
//  - Grant when !lock: only one valid -> that port; both valid -> port rr_ptr. a_valid = granted valid.
//  - aK_ready = a_ready & (granted==K); ungranted port sees ready=0.
//  - Stall lock: a_valid & !a_ready -> lock=1 on granted port (TL valid/payload stability), no regrant.
//  - Burst: opcode PutFull(0)/PutPartial(1) with size>3 -> beats = 1<<(size-3) (max 8 at size 6).
//    First-beat fire: lock=1, beats_left=beats-1; each later fire decrements; lock clears on last-beat fire.
//  - Single-beat fire (Get, size<=3 Put, others): no lock held afterward.
//  - rr_ptr <= ~granted on each burst-first / single-beat fire (never mid-burst).
//  - a_source = {granted, aK_source}; other fields passed unchanged.
//  - D: dK_valid = d_valid & (d_source[SRC_W]==K); d_ready = dK_ready of addressed port.
//    D needs no lock: each beat routed independently; multi-beat AccessAckData needs no tracking.
//  - Simultaneous: A fire and D fire in same cycle are independent.
//  - Reset mid-burst: lock and beats_left clear asynchronously; protocol recovery is upstream's job.
//  - size>6 Put: beats clamp to 8 (illegal per bus width, not checked).
// CONFIGURATION
//  TL_SRC_ARB_PERF_EN defined: adds outputs perf_gnt0, perf_gnt1 (32b, wrap) counting A first-beat
//    fires per port, and perf_conflict (32b) counting cycles both aK_valid with !lock; all reset to 0.
//  Undefined: ports and counters absent; arbitration identical.
// STRUCTURE
//  Shared package tl_pkg: opcode constants (PUT_FULL=0, PUT_PART=1, GET=4, ACK=0, ACK_DATA=1),
//    BEAT_LG, function tl_beats(size) -> 4b beat count.
//  One sub-module tl_beat_counter (first/last-beat detect from size/opcode/fire); rest flat.
// TESTING
//  1. Both ports Get size 3, a_ready=1 -> grants 0 then 1 then 0; a_source = 0x00|src, 0x40|src.
//  2. Port 0 PutFull size 6 (8 beats) while port 1 valid -> 8 consecutive port-0 beats, then port 1.
//  3. a_ready=0 for 3 cycles with port 0 granted, port 1 raises valid -> grant stays port 0, payload stable.
//  4. d_source=0x45, d_valid=1 -> d1_valid=1, d1 source=0x05, d0_valid=0; d_ready follows d1_ready.
//  5. Drop reset_n mid 4-beat burst -> lock=0, rr_ptr=0; next contention grants port 0.
//  6. PERF_EN: 5 port-0 fires, 3 port-1, 2 conflict cycles -> perf_gnt0=5, perf_gnt1=3, perf_conflict=2.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and the beat-count helper used by the source arbiter.
package tl_pkg;

    localparam logic [2:0] PUT_FULL = 3'd0;
    localparam logic [2:0] PUT_PART = 3'd1;
    localparam logic [2:0] GET      = 3'd4;
    localparam logic [2:0] ACK      = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;

    localparam int unsigned BEAT_LG = 3;

    // Beats needed for a transfer of 2**size bytes on the bus; clamps at 8 beats.
    function automatic logic [3:0] tl_beats(input logic [2:0] size);
        logic [2:0] lg;
        if (size <= 3'(BEAT_LG)) begin
            return 4'd1;
        end
        lg = size - 3'(BEAT_LG);
        if (lg > 3'd3) begin
            lg = 3'd3;
        end
        return 4'd1 << lg;
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks remaining beats of an A-channel Put burst; flags first and last beat of a transfer.
module tl_beat_counter
    import tl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       fire,
    input  logic [2:0] opcode,
    input  logic [2:0] size,
    output logic       first,
    output logic       last
);

    logic [3:0] beats;
    logic [3:0] beats_left_q, beats_left_d;

    always_comb begin
        beats = (opcode == PUT_FULL || opcode == PUT_PART) ? tl_beats(size) : 4'd1;
        first = (beats_left_q == 4'd0);
        last  = first ? (beats == 4'd1) : (beats_left_q == 4'd1);
        beats_left_d = beats_left_q;
        if (fire) begin
            beats_left_d = first ? beats - 4'd1 : beats_left_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            beats_left_q <= 4'd0;
        end else begin
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: rtl/tl_src_arbiter.sv
// 2:1 TileLink-UL A/D arbiter with round-robin grant and burst/stall locking.
// Optional TL_SRC_ARB_PERF_EN adds grant and conflict performance counters.
module tl_src_arbiter
    import tl_pkg::*;
#(
    parameter int unsigned ADDR_W = 31,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SRC_W  = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a0_valid,
    output logic                a0_ready,
    input  logic [2:0]          a0_opcode,
    input  logic [2:0]          a0_param,
    input  logic [2:0]          a0_size,
    input  logic [SRC_W-1:0]    a0_source,
    input  logic [ADDR_W-1:0]   a0_address,
    input  logic [DATA_W/8-1:0] a0_mask,
    input  logic [DATA_W-1:0]   a0_data,
    input  logic                a1_valid,
    output logic                a1_ready,
    input  logic [2:0]          a1_opcode,
    input  logic [2:0]          a1_param,
    input  logic [2:0]          a1_size,
    input  logic [SRC_W-1:0]    a1_source,
    input  logic [ADDR_W-1:0]   a1_address,
    input  logic [DATA_W/8-1:0] a1_mask,
    input  logic [DATA_W-1:0]   a1_data,
    output logic                a_valid,
    input  logic                a_ready,
    output logic [2:0]          a_opcode,
    output logic [2:0]          a_param,
    output logic [2:0]          a_size,
    output logic [SRC_W:0]      a_source,
    output logic [ADDR_W-1:0]   a_address,
    output logic [DATA_W/8-1:0] a_mask,
    output logic [DATA_W-1:0]   a_data,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [1:0]          d_param,
    input  logic [2:0]          d_size,
    input  logic [SRC_W:0]      d_source,
    input  logic                d_denied,
    input  logic                d_corrupt,
    input  logic [DATA_W-1:0]   d_data,
    output logic                d0_valid,
    input  logic                d0_ready,
    output logic [2:0]          d0_opcode,
    output logic [1:0]          d0_param,
    output logic [2:0]          d0_size,
    output logic [SRC_W-1:0]    d0_source,
    output logic                d0_denied,
    output logic                d0_corrupt,
    output logic [DATA_W-1:0]   d0_data,
    output logic                d1_valid,
    input  logic                d1_ready,
    output logic [2:0]          d1_opcode,
    output logic [1:0]          d1_param,
    output logic [2:0]          d1_size,
    output logic [SRC_W-1:0]    d1_source,
    output logic                d1_denied,
    output logic                d1_corrupt,
    output logic [DATA_W-1:0]   d1_data
`ifdef TL_SRC_ARB_PERF_EN
    ,
    output logic [31:0]         perf_gnt0,
    output logic [31:0]         perf_gnt1,
    output logic [31:0]         perf_conflict
`endif
);

    logic rr_q, lock_q, lock_port_q;
    logic gnt, fire, stall, first, last;

    always_comb begin
        if (lock_q) begin
            gnt = lock_port_q;
        end else if (a0_valid != a1_valid) begin
            gnt = a1_valid;
        end else begin
            gnt = rr_q;
        end
        a_valid   = reset_n & (gnt ? a1_valid : a0_valid);
        a0_ready  = reset_n & a_ready & ~gnt;
        a1_ready  = reset_n & a_ready & gnt;
        fire      = a_valid & a_ready;
        stall     = a_valid & ~a_ready;
        a_opcode  = gnt ? a1_opcode : a0_opcode;
        a_param   = gnt ? a1_param : a0_param;
        a_size    = gnt ? a1_size : a0_size;
        a_source  = {gnt, gnt ? a1_source : a0_source};
        a_address = gnt ? a1_address : a0_address;
        a_mask    = gnt ? a1_mask : a0_mask;
        a_data    = gnt ? a1_data : a0_data;
    end

    tl_beat_counter u_beat_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .fire    (fire),
        .opcode  (a_opcode),
        .size    (a_size),
        .first   (first),
        .last    (last)
    );

    // Hold the grant while a burst is open or a presented beat is stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_q        <= 1'b0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
        end else begin
            lock_q      <= fire ? ~last : (~first | stall);
            lock_port_q <= gnt;
            if (fire && first) begin
                rr_q <= ~gnt;
            end
        end
    end

    always_comb begin
        d0_valid   = reset_n & d_valid & ~d_source[SRC_W];
        d1_valid   = reset_n & d_valid & d_source[SRC_W];
        d_ready    = d_source[SRC_W] ? d1_ready : d0_ready;
        d0_opcode  = d_opcode;
        d0_param   = d_param;
        d0_size    = d_size;
        d0_source  = d_source[SRC_W-1:0];
        d0_denied  = d_denied;
        d0_corrupt = d_corrupt;
        d0_data    = d_data;
        d1_opcode  = d_opcode;
        d1_param   = d_param;
        d1_size    = d_size;
        d1_source  = d_source[SRC_W-1:0];
        d1_denied  = d_denied;
        d1_corrupt = d_corrupt;
        d1_data    = d_data;
    end

`ifdef TL_SRC_ARB_PERF_EN
    logic [31:0] gnt0_q, gnt1_q, conflict_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt0_q     <= 32'd0;
            gnt1_q     <= 32'd0;
            conflict_q <= 32'd0;
        end else begin
            if (fire && first && !gnt) gnt0_q <= gnt0_q + 32'd1;
            if (fire && first && gnt) gnt1_q <= gnt1_q + 32'd1;
            if (a0_valid && a1_valid && !lock_q) conflict_q <= conflict_q + 32'd1;
        end
    end

    assign perf_gnt0     = gnt0_q;
    assign perf_gnt1     = gnt1_q;
    assign perf_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_tl_src_arbiter.sv
// Directed bench for tl_src_arbiter with a transaction-level reference model checked every cycle.
module tb_tl_src_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a0_valid, a0_ready, a1_valid, a1_ready;
    logic [2:0]  a0_opcode, a0_param, a0_size, a1_opcode, a1_param, a1_size;
    logic [5:0]  a0_source, a1_source;
    logic [30:0] a0_address, a1_address;
    logic [7:0]  a0_mask, a1_mask;
    logic [63:0] a0_data, a1_data;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [6:0]  a_source;
    logic [30:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_param;
    logic [6:0]  d_source;
    logic [63:0] d_data;
    logic        d0_valid, d0_ready, d0_denied, d0_corrupt;
    logic        d1_valid, d1_ready, d1_denied, d1_corrupt;
    logic [2:0]  d0_opcode, d0_size, d1_opcode, d1_size;
    logic [1:0]  d0_param, d1_param;
    logic [5:0]  d0_source, d1_source;
    logic [63:0] d0_data, d1_data;
`ifdef TL_SRC_ARB_PERF_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    tl_src_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
        .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask),
        .a0_data(a0_data),
        .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
        .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask),
        .a1_data(a1_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .d_data(d_data),
        .d0_valid(d0_valid), .d0_ready(d0_ready), .d0_opcode(d0_opcode), .d0_param(d0_param),
        .d0_size(d0_size), .d0_source(d0_source), .d0_denied(d0_denied),
        .d0_corrupt(d0_corrupt), .d0_data(d0_data),
        .d1_valid(d1_valid), .d1_ready(d1_ready), .d1_opcode(d1_opcode), .d1_param(d1_param),
        .d1_size(d1_size), .d1_source(d1_source), .d1_denied(d1_denied),
        .d1_corrupt(d1_corrupt), .d1_data(d1_data)
`ifdef TL_SRC_ARB_PERF_EN
        ,
        .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: held = port owning the channel (-1 free), pref = round-robin choice.
    int held = -1;
    int pref = 0;
    int left = 0;
    int m_g0 = 0, m_g1 = 0, m_conf = 0;
    int fire_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int beats_of(input int op, input int size);
        int e;
        if ((op == 0 || op == 1) && size > 3) begin
            e = size - 3;
            if (e > 3) e = 3;
            return 1 << e;
        end
        return 1;
    endfunction

    function automatic int exp_gnt();
        if (held >= 0) return held;
        if (a0_valid && !a1_valid) return 0;
        if (a1_valid && !a0_valid) return 1;
        return pref;
    endfunction

    // Model update at each clock edge / reset assertion.
    initial begin
        int g;
        logic v;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                held = -1; pref = 0; left = 0;
                m_g0 = 0; m_g1 = 0; m_conf = 0;
            end else begin
                g = exp_gnt();
                v = (g == 1) ? a1_valid : a0_valid;
                if (held < 0 && a0_valid && a1_valid) m_conf++;
                if (v && a_ready) begin
                    fire_log.push_back(g);
                    if (left == 0) begin
                        pref = 1 - g;
                        left = (g == 1) ? beats_of(int'(a1_opcode), int'(a1_size)) - 1
                                        : beats_of(int'(a0_opcode), int'(a0_size)) - 1;
                        if (g == 1) m_g1++; else m_g0++;
                    end else begin
                        left--;
                    end
                    held = (left > 0) ? g : -1;
                end else if (v) begin
                    held = g;
                end else if (left == 0) begin
                    held = -1;
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        int g;
        logic ev, gb;
        forever begin
            @(negedge clock);
            g  = exp_gnt();
            gb = (g == 1);
            ev = reset_n && (gb ? a1_valid : a0_valid);
            chk("a_valid", a_valid, ev);
            chk("a0_ready", a0_ready, reset_n && a_ready && !gb);
            chk("a1_ready", a1_ready, reset_n && a_ready && gb);
            if (ev) begin
                chk("a_source", a_source, {gb, gb ? a1_source : a0_source});
                chk("a_opcode", a_opcode, gb ? a1_opcode : a0_opcode);
                chk("a_size", a_size, gb ? a1_size : a0_size);
                chk("a_address", a_address, gb ? a1_address : a0_address);
                chk("a_data", a_data, gb ? a1_data : a0_data);
            end
            chk("d0_valid", d0_valid, reset_n && d_valid && !d_source[6]);
            chk("d1_valid", d1_valid, reset_n && d_valid && d_source[6]);
            chk("d_ready", d_ready, d_source[6] ? d1_ready : d0_ready);
            if (d_valid) begin
                chk("d0_source", d0_source, d_source[5:0]);
                chk("d1_source", d1_source, d_source[5:0]);
                chk("d1_data", d1_data, d_data);
                chk("d0_denied", d0_denied, d_denied);
            end
`ifdef TL_SRC_ARB_PERF_EN
            chk("perf_gnt0", perf_gnt0, 32'(m_g0));
            chk("perf_gnt1", perf_gnt1, 32'(m_g1));
            chk("perf_conflict", perf_conflict, 32'(m_conf));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drv0(input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [5:0] src, input logic [63:0] dat);
        a0_valid = v; a0_opcode = op; a0_param = 3'd0; a0_size = sz; a0_source = src;
        a0_address = {25'h0, src} + 31'h1000; a0_mask = 8'hff; a0_data = dat;
    endtask

    task automatic drv1(input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [5:0] src, input logic [63:0] dat);
        a1_valid = v; a1_opcode = op; a1_param = 3'd0; a1_size = sz; a1_source = src;
        a1_address = {25'h0, src} + 31'h2000; a1_mask = 8'h0f; a1_data = dat;
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, 64'(fire_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < fire_log.size(); i++) begin
            chk(name, 64'(fire_log[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        logic [6:0] t1_src [4];
        int exp_q[$];
        t1_src = '{7'h05, 7'h47, 7'h05, 7'h47};

        // Reset: requests present but everything gated off.
        drv0(1'b1, 3'd4, 3'd3, 6'd5, 64'h0);
        drv1(1'b0, 3'd4, 3'd3, 6'd7, 64'h0);
        a_ready = 1'b1;
        d_valid = 1'b1; d_source = 7'h00; d_opcode = 3'd1; d_param = 2'd0; d_size = 3'd3;
        d_denied = 1'b0; d_corrupt = 1'b0; d_data = 64'hdead_beef_0000_0001;
        d0_ready = 1'b1; d1_ready = 1'b0;
        #1;
        chk("rst_a_valid", a_valid, 1'b0);
        chk("rst_a0_ready", a0_ready, 1'b0);
        chk("rst_d0_valid", d0_valid, 1'b0);
        cyc(2);
        reset_n = 1'b1;
        a0_valid = 1'b0; d_valid = 1'b0;
        cyc(1);

        // Both ports Get size 3: alternating grant with port tag on source.
        fire_log.delete();
        drv0(1'b1, 3'd4, 3'd3, 6'd5, 64'h11);
        drv1(1'b1, 3'd4, 3'd3, 6'd7, 64'h22);
        for (int i = 0; i < 4; i++) begin
            #3 chk("t1_src", a_source, t1_src[i]);
            cyc(1);
        end
        a0_valid = 1'b0; a1_valid = 1'b0;
        exp_q = '{0, 1, 0, 1};
        chk_log("t1_gnt", exp_q);

        // 8-beat PutFull on port 0 holds the grant against port 1.
        fire_log.delete();
        drv1(1'b1, 3'd4, 3'd3, 6'd2, 64'h33);
        for (int i = 0; i < 9; i++) begin
            drv0(1'b1, 3'd0, 3'd6, 6'd3, 64'(i) + 64'h100);
            cyc(1);
        end
        a0_valid = 1'b0; a1_valid = 1'b0;
        exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        chk_log("t2_gnt", exp_q);

        // Stall: port 0 presented while a_ready low keeps the grant when port 1 arrives.
        fire_log.delete();
        drv0(1'b1, 3'd4, 3'd3, 6'd9, 64'h44);
        cyc(1);
        a_ready = 1'b0;
        cyc(1);
        drv1(1'b1, 3'd4, 3'd3, 6'd2, 64'h55);
        for (int i = 0; i < 3; i++) begin
            #3 chk("t3_src", a_source, 7'h09);
            chk("t3_a1_ready", a1_ready, 1'b0);
            cyc(1);
        end
        a_ready = 1'b1;
        #3 chk("t3_src_rel", a_source, 7'h09);
        cyc(2);
        a0_valid = 1'b0; a1_valid = 1'b0;
        exp_q = '{0, 0, 1};
        chk_log("t3_gnt", exp_q);

        // D routing by source MSB.
        d_valid = 1'b1; d_source = 7'h45; d1_ready = 1'b1; d0_ready = 1'b0;
        d_data = 64'h0123_4567_89ab_cdef;
        #3 chk("t4_d1_valid", d1_valid, 1'b1);
        chk("t4_d1_source", d1_source, 6'h05);
        chk("t4_d0_valid", d0_valid, 1'b0);
        chk("t4_d_ready", d_ready, 1'b1);
        cyc(1);
        d1_ready = 1'b0;
        #3 chk("t4_d_ready_lo", d_ready, 1'b0);
        cyc(1);
        d_source = 7'h03; d0_ready = 1'b1;
        #3 chk("t4_d0_valid", d0_valid, 1'b1);
        chk("t4_d1_valid_lo", d1_valid, 1'b0);
        chk("t4_d0_source", d0_source, 6'h03);
        cyc(1);
        d_valid = 1'b0;

        // Reset in the middle of a 4-beat burst on port 0.
        fire_log.delete();
        drv0(1'b1, 3'd0, 3'd5, 6'd4, 64'h66);
        cyc(2);
        reset_n = 1'b0;
        #3 chk("t5_rst_valid", a_valid, 1'b0);
        cyc(1);
        reset_n = 1'b1;
        drv0(1'b1, 3'd4, 3'd3, 6'd4, 64'h77);
        drv1(1'b1, 3'd4, 3'd3, 6'd6, 64'h88);
        #3 chk("t5_src", a_source, 7'h04);
        cyc(2);
        a0_valid = 1'b0; a1_valid = 1'b0;
        exp_q = '{0, 0, 0, 1};
        chk_log("t5_gnt", exp_q);

        // Oversized PutPartial clamps to 8 beats.
        fire_log.delete();
        drv0(1'b1, 3'd4, 3'd3, 6'd1, 64'h99);
        drv1(1'b1, 3'd1, 3'd7, 6'd8, 64'haa);
        cyc(10);
        a0_valid = 1'b0; a1_valid = 1'b0;
        exp_q = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        chk_log("t7_gnt", exp_q);

`ifdef TL_SRC_ARB_PERF_EN
        // Counters: 5 port-0 fires, 3 port-1 fires, 2 conflict cycles.
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        drv0(1'b1, 3'd4, 3'd3, 6'd1, 64'h1);
        drv1(1'b1, 3'd4, 3'd3, 6'd2, 64'h2);
        cyc(2);
        a1_valid = 1'b0;
        cyc(4);
        a0_valid = 1'b0; a1_valid = 1'b1;
        cyc(2);
        a1_valid = 1'b0;
        #3 chk("t6_gnt0", perf_gnt0, 32'd5);
        chk("t6_gnt1", perf_gnt1, 32'd3);
        chk("t6_conflict", perf_conflict, 32'd2);
`endif

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
